multiword_adder: RTL
====================

Name: multiword_adder

Overview:
- Sequential front-end that adds operands wider than one adder word, streamed least-significant word first.
- One word is added per accepted beat through one instance of the team's carry_select_adder. The carry-out of each word is registered and chained into the next word of the same transaction.
- Sits between operand producers (register file, bignum/crypto datapaths) and result consumers.
- Uses a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32: bits per word. Must be an integer multiple of BLOCK_WIDTH.
- BLOCK_WIDTH, 4: block size passed to carry_select_adder.
- MAX_WORDS, 8: maximum words per transaction. Must be at least 2.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- operand_A_i  in  DATA_WIDTH  word of operand A.
- operand_B_i  in  DATA_WIDTH  word of operand B.
- carry_i  in  1  external carry-in. Used only on the first word of a transaction.
- last_i  in  1  marks the most-significant (final) word of the transaction.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept an input beat.
- result_o  out  DATA_WIDTH  sum word.
- carry_o  out  1  carry-out of this word.
- overflow_o  out  1  signed overflow. Meaningful only when last_o=1, otherwise 0.
- word_idx_o  out  $clog2(MAX_WORDS)  index of this word within its transaction. LSW = 0.
- last_o  out  1  final word of the transaction.
- error_o  out  1  transaction was truncated at MAX_WORDS.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the output beat.

Behaviour:
- Reset is asynchronous, active-low. While rst_n_i=0 all of the following are 0: valid_o, result_o, carry_o, overflow_o, word_idx_o, last_o, error_o, the internal carry register, and the word counter. FSM goes to IDLE.
- Reset mid-transaction discards the partial transaction. The next accepted beat starts a new transaction in IDLE.
- Handshake:
  - Input beat accepted when valid_i & ready_o.
  - Output beat consumed when valid_o & ready_i.
  - ready_o = ~valid_o | ready_i (single output register, full throughput).
  - Output fields are held stable while valid_o=1 and ready_i=0.
- Latency: one cycle. An accepted beat appears on the outputs on the next rising edge.
- FSM states:
  - IDLE (expecting first word): adder carry-in = carry_i; word counter = 0.
  - CHAIN (mid-transaction): adder carry-in = internal carry register; carry_i is ignored.
- Transitions, on accept only:
  - IDLE→CHAIN when the beat is not final.
  - CHAIN→IDLE when the beat is final.
  - IDLE→IDLE for a single-word transaction.
  - No transition and no register update when no beat is accepted.
- Final beat = last_i OR word counter == MAX_WORDS-1.
  - If forced final by the counter while last_i=0: last_o=1 and error_o=1 for that beat.
  - Any following words form a new transaction.
- On each accepted beat:
  - Internal carry register ← adder carry-out.
  - Word counter ← 0 if final, else +1. The counter never wraps past MAX_WORDS-1.
- overflow_o on a final beat = (A[MSB] == B[MSB]) & (result[MSB] != A[MSB]), computed with that word's operands.
- carry_o on the final beat is the unsigned carry-out of the full multiword sum.
- Simultaneous output consume and input accept in the same cycle: the output register reloads with the new beat, with no bubble.
- Input is not accepted while the output is stalled. Chain state is frozen during the stall.

Decomposition:
- Shared package: typedef for the FSM state enum (IDLE, CHAIN).
- Shared package: a packed struct for the output beat (result, carry, overflow, idx, last, error), reusable by future sequential arithmetic wrappers.
- Sub-module: one carry_select_adder instance, with DATA_WIDTH and BLOCK_WIDTH passed through.
- Remaining logic (FSM, carry register, counter, output register) stays in this module.

Test Plan (DATA_WIDTH=8, BLOCK_WIDTH=4, MAX_WORDS=4, ready_i=1 unless noted):
1. Single word: A=0x7F, B=0x01, carry_i=0, last_i=1 → next cycle valid_o=1, result_o=0x80, carry_o=0, overflow_o=1, last_o=1, word_idx_o=0.
2. Three-word chain: A=FF,FF,FF; B=01,00,00; carry_i=0; last_i on 3rd word → results 00,00,00; carry_o 1,1,1; word_idx_o 0,1,2; last_o only on 3rd; overflow_o=0.
3. Carry-in usage: first word A=0x10, B=0x20, carry_i=1 → 0x31. Second word A=0x00, B=0x00, carry_i=1, last_i=1 → 0x00, because carry_i is ignored in CHAIN.
4. Backpressure: ready_i=0 for 3 cycles during a 2-word stream → ready_o=0, outputs stable, no beat lost or duplicated. After release, both words arrive in order with correct chaining.
5. Reset mid-transaction: accept A=FF, B=01 (not last), pulse rst_n_i low → outputs 0. Then A=01, B=01, carry_i=0, last_i=1 → result_o=0x02, word_idx_o=0, with no stale carry.
6. Truncation: 5 words of A=01, B=00 with last_i=0 throughout → 4th output has last_o=1, error_o=1, word_idx_o=3. 5th output has word_idx_o=0, result_o=0x01.

Source files
------------

// File: rtl/multiword_adder_pkg.sv
// Shared types for sequential multiword arithmetic wrappers.
// Holds the chain FSM state and the registered output beat layout.
package multiword_adder_pkg;

   // Widest word / index any wrapper may use; narrower ones zero-pad
   localparam int unsigned MWA_MAX_DW = 256;
   localparam int unsigned MWA_MAX_IW = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CHAIN = 1'b1
   } mwa_state_e;

   typedef struct packed {
      logic [MWA_MAX_DW-1:0] result;
      logic                  carry;
      logic                  overflow;
      logic [MWA_MAX_IW-1:0] idx;
      logic                  last;
      logic                  error;
   } mwa_beat_t;

endpackage

// File: rtl/multiword_adder_csa.sv
// Carry-select adder: i_a + i_b + i_carry -> {o_carry, o_sum}.
// Each block precomputes sums for carry-in 0/1 and selects on the real carry.
module carry_select_adder #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BLOCK_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic                  i_carry,
   output logic [DATA_WIDTH-1:0] o_sum,
   output logic                  o_carry
);

   localparam int unsigned NB = DATA_WIDTH / BLOCK_WIDTH;

   logic [NB:0] w_c;

   assign w_c[0]  = i_carry;
   assign o_carry = w_c[NB];

   for (genvar g = 0; g < NB; g++) begin : g_blk
      logic [BLOCK_WIDTH-1:0] w_a;
      logic [BLOCK_WIDTH-1:0] w_b;
      logic [BLOCK_WIDTH:0]   w_s0;
      logic [BLOCK_WIDTH:0]   w_s1;

      assign w_a  = i_a[g*BLOCK_WIDTH +: BLOCK_WIDTH];
      assign w_b  = i_b[g*BLOCK_WIDTH +: BLOCK_WIDTH];
      assign w_s0 = {1'b0, w_a} + {1'b0, w_b};
      assign w_s1 = {1'b0, w_a} + {1'b0, w_b}
                  + {{BLOCK_WIDTH{1'b0}}, 1'b1};

      assign o_sum[g*BLOCK_WIDTH +: BLOCK_WIDTH] =
         w_c[g] ? w_s1[BLOCK_WIDTH-1:0] : w_s0[BLOCK_WIDTH-1:0];
      assign w_c[g+1] = w_c[g] ? w_s1[BLOCK_WIDTH] : w_s0[BLOCK_WIDTH];
   end

endmodule

// File: rtl/multiword_adder.sv
// Streams wide operands LSW-first, one word per beat, chaining the carry.
// Ports: clk_i/rst_n_i; in beat operand_A_i, operand_B_i, carry_i, last_i,
// valid_i/ready_o; out beat result_o, carry_o, overflow_o, word_idx_o,
// last_o, error_o, valid_o/ready_i. One-cycle latency, full throughput.
module multiword_adder
   import multiword_adder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BLOCK_WIDTH = 4,
   parameter int unsigned MAX_WORDS   = 8,
   localparam int unsigned IDX_W      = $clog2(MAX_WORDS)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_WIDTH-1:0] operand_A_i,
   input  logic [DATA_WIDTH-1:0] operand_B_i,
   input  logic                  carry_i,
   input  logic                  last_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  carry_o,
   output logic                  overflow_o,
   output logic [IDX_W-1:0]      word_idx_o,
   output logic                  last_o,
   output logic                  error_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   if (DATA_WIDTH % BLOCK_WIDTH != 0) begin : g_chk_blk
      $error("DATA_WIDTH must be a multiple of BLOCK_WIDTH");
   end
   if (MAX_WORDS < 2) begin : g_chk_mw
      $error("MAX_WORDS must be at least 2");
   end
   if (DATA_WIDTH > MWA_MAX_DW || IDX_W > MWA_MAX_IW) begin : g_chk_w
      $error("width exceeds package beat layout");
   end

   localparam int unsigned MSB = DATA_WIDTH - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

   mwa_state_e            r_state;
   mwa_state_e            w_state_nxt;
   logic                  r_carry;
   logic [IDX_W-1:0]      r_cnt;
   logic                  r_valid;
   mwa_beat_t             r_beat;
   mwa_beat_t             w_beat;

   logic                  w_accept;
   logic                  w_cin;
   logic                  w_cnt_max;
   logic                  w_final;
   logic [DATA_WIDTH-1:0] w_sum;
   logic                  w_cout;
   logic                  w_unused;

   assign ready_o  = ~r_valid | ready_i;
   assign w_accept = valid_i & ready_o;

   // Only the first word of a transaction takes the external carry
   assign w_cin     = (r_state == CHAIN) ? r_carry : carry_i;
   assign w_cnt_max = (r_cnt == LAST_IDX);
   assign w_final   = last_i | w_cnt_max;

   carry_select_adder #(
      .DATA_WIDTH  (DATA_WIDTH),
      .BLOCK_WIDTH (BLOCK_WIDTH)
   ) u_csa (
      .i_a     (operand_A_i),
      .i_b     (operand_B_i),
      .i_carry (w_cin),
      .o_sum   (w_sum),
      .o_carry (w_cout)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         unique case (r_state)
            IDLE:    w_state_nxt = w_final ? IDLE : CHAIN;
            CHAIN:   w_state_nxt = w_final ? IDLE : CHAIN;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_beat                    = '0;
      w_beat.result[MSB:0]      = w_sum;
      w_beat.carry              = w_cout;
      w_beat.idx[IDX_W-1:0]     = r_cnt;
      w_beat.last               = w_final;
      // Counter forced the end without the producer marking it
      w_beat.error              = w_cnt_max & ~last_i;
      w_beat.overflow           = w_final
                                & (operand_A_i[MSB] == operand_B_i[MSB])
                                & (w_sum[MSB] != operand_A_i[MSB]);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_beat  <= w_beat;
            r_valid <= 1'b1;
            r_carry <= w_cout;
            r_cnt   <= w_final ? '0 : r_cnt + 1'b1;
         end else if (ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign valid_o    = r_valid;
   assign result_o   = r_beat.result[MSB:0];
   assign carry_o    = r_beat.carry;
   assign overflow_o = r_beat.overflow;
   assign word_idx_o = r_beat.idx[IDX_W-1:0];
   assign last_o     = r_beat.last;
   assign error_o    = r_beat.error;

   // Padding bits of the shared beat layout are never driven non-zero
   assign w_unused = ^r_beat;

endmodule
